sha1_msg_ctrl: RTL and testbench

Message-level sequencer for the `sha1_unit` compression core. It accepts pre-padded 512-bit blocks on an AXI-Stream-style input and issues each block to the core with the current chaining value. It adds each core result into the chaining state modulo 2^32 and emits the 160-bit digest after the block marked last. It sits between the padding/framing front end and the digest consumer, and owns all multi-block state.

---
 rtl/sha1_pkg.sv | 31 +++
 rtl/sha1_msg_ctrl.sv | 151 +++++++++++++++
 tb/tb_sha1_msg_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 controller types: IV constants, FSM state enum, 5x32 hash word type.
// Combinational helper only; no latency, no flow control.
package sha1_pkg;

    localparam logic [31:0] SHA1_H0 = 32'h67452301;
    localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
    localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
    localparam logic [31:0] SHA1_H3 = 32'h10325476;
    localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;

    // Word index 0 holds H0.
    typedef logic [4:0][31:0] sha1_hash_t;

    localparam sha1_hash_t SHA1_IV = {SHA1_H4, SHA1_H3, SHA1_H2, SHA1_H1, SHA1_H0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } sha1_ctrl_state_t;

    function automatic sha1_hash_t sha1_hash_add(input sha1_hash_t a, input sha1_hash_t b);
        sha1_hash_t s;
        for (int i = 0; i < 5; i++) begin
            s[i] = a[i] + b[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/sha1_msg_ctrl.sv
// Multi-block SHA-1 sequencer: feeds each padded block plus chaining value to the core, folds results, emits digest.
// 2 cycles per block + 1 for digest, plus core latency; digest backpressure stalls input, one block in flight.
module sha1_msg_ctrl
    import sha1_pkg::*;
#(
    parameter int BLK_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [511:0]          s_tdata,
    input  logic                  s_tlast,

    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [159:0]          m_tdigest,
    output logic [BLK_CNT_W-1:0]  m_tblocks,

    output logic                  u_tvalid_in,
    input  logic                  u_tready_in,
    output logic [79:0][31:0]     u_data_in,
    output logic [31:0]           u_A,
    output logic [31:0]           u_B,
    output logic [31:0]           u_C,
    output logic [31:0]           u_D,
    output logic [31:0]           u_E,
    output logic                  u_tready_out,
    input  logic                  u_tvalid_out,
    input  logic [31:0]           r_A,
    input  logic [31:0]           r_B,
    input  logic [31:0]           r_C,
    input  logic [31:0]           r_D,
    input  logic [31:0]           r_E
);

    sha1_ctrl_state_t       state, state_nxt;
    logic                   live_q;
    logic [511:0]           blk_q;
    logic                   last_q;
    logic                   first_q;
    logic [BLK_CNT_W-1:0]   cnt_q;
    sha1_hash_t             chain_q;
    sha1_hash_t             res;

    logic                   blk_acc;
    logic                   res_acc;
    logic                   dig_acc;

    assign res = {r_E, r_D, r_C, r_B, r_A};

    // live_q keeps s_tready low while reset is held and until the first edge after release.
    always_comb begin
        state_nxt    = state;
        s_tready     = 1'b0;
        u_tvalid_in  = 1'b0;
        u_tready_out = 1'b0;
        m_tvalid     = 1'b0;
        blk_acc      = 1'b0;
        res_acc      = 1'b0;
        dig_acc      = 1'b0;
        unique case (state)
            IDLE: begin
                s_tready = live_q;
                if (live_q && s_tvalid) begin
                    blk_acc   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                u_tvalid_in = 1'b1;
                if (u_tready_in) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                u_tready_out = 1'b1;
                if (u_tvalid_out) begin
                    res_acc   = 1'b1;
                    state_nxt = last_q ? OUT : IDLE;
                end
            end
            OUT: begin
                m_tvalid = 1'b1;
                if (m_tready) begin
                    dig_acc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            live_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            live_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_q   <= '0;
            last_q  <= 1'b0;
            first_q <= 1'b1;
            cnt_q   <= '0;
            chain_q <= SHA1_IV;
        end else begin
            if (blk_acc) begin
                blk_q   <= s_tdata;
                last_q  <= s_tlast;
                first_q <= 1'b0;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + BLK_CNT_W'(1);
                end
                if (first_q) begin
                    chain_q <= SHA1_IV;
                end
            end
            if (res_acc) begin
                chain_q <= sha1_hash_add(chain_q, res);
            end
            if (dig_acc) begin
                first_q <= 1'b1;
                cnt_q   <= '0;
            end
        end
    end

    // Message words fill the first 16 schedule slots; the core expands the rest itself.
    always_comb begin
        u_data_in = '0;
        for (int i = 0; i < 16; i++) begin
            u_data_in[i] = blk_q[511 - 32*i -: 32];
        end
    end

    assign u_A = (state == ISSUE) ? chain_q[0] : 32'h0;
    assign u_B = (state == ISSUE) ? chain_q[1] : 32'h0;
    assign u_C = (state == ISSUE) ? chain_q[2] : 32'h0;
    assign u_D = (state == ISSUE) ? chain_q[3] : 32'h0;
    assign u_E = (state == ISSUE) ? chain_q[4] : 32'h0;

    assign m_tdigest = (state == OUT) ? {chain_q[0], chain_q[1], chain_q[2], chain_q[3], chain_q[4]} : 160'h0;
    assign m_tblocks = (state == OUT) ? cnt_q : '0;

endmodule

// File: tb/tb_sha1_msg_ctrl.sv
// Bench for sha1_msg_ctrl: 10-cycle stub core with programmable results, queue-based message model.
module tb_sha1_msg_ctrl;

    localparam int CW = 3;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               s_tvalid = 1'b0;
    logic               s_tready;
    logic [511:0]       s_tdata = '0;
    logic               s_tlast = 1'b0;
    logic               m_tvalid;
    logic               m_tready = 1'b1;
    logic [159:0]       m_tdigest;
    logic [CW-1:0]      m_tblocks;
    logic               u_tvalid_in;
    logic               u_tready_in = 1'b1;
    logic [79:0][31:0]  u_data_in;
    logic [31:0]        u_A, u_B, u_C, u_D, u_E;
    logic               u_tready_out;
    logic               u_tvalid_out = 1'b0;
    logic [31:0]        r_A = '0, r_B = '0, r_C = '0, r_D = '0, r_E = '0;

    int tests = 0;
    int fails = 0;

    logic [159:0] exp_in_q[$];
    logic [511:0] exp_blk_q[$];
    logic [159:0] res_q[$];
    logic [159:0] exp_dig_q[$];
    int           exp_cnt_q[$];

    logic [159:0] last_dig = '0;
    logic [159:0] last_core_in = '0;
    int           last_blocks = 0;
    int           m_stall = 0;
    int           in_stall = 0;

    sha1_msg_ctrl #(.BLK_CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdigest(m_tdigest), .m_tblocks(m_tblocks),
        .u_tvalid_in(u_tvalid_in), .u_tready_in(u_tready_in), .u_data_in(u_data_in),
        .u_A(u_A), .u_B(u_B), .u_C(u_C), .u_D(u_D), .u_E(u_E),
        .u_tready_out(u_tready_out), .u_tvalid_out(u_tvalid_out),
        .r_A(r_A), .r_B(r_B), .r_C(r_C), .r_D(r_D), .r_E(r_E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-word modulo-2^32 sum, words packed H0 at the top.
    function automatic logic [159:0] hadd(input logic [159:0] a, input logic [159:0] b);
        logic [159:0] s;
        for (int k = 0; k < 5; k++) begin
            s[32*k +: 32] = a[32*k +: 32] + b[32*k +: 32];
        end
        return s;
    endfunction

    task automatic reset_checks();
        chk("rst_s_tready", 512'(s_tready), 512'(0));
        chk("rst_m_tvalid", 512'(m_tvalid), 512'(0));
        chk("rst_u_tvalid_in", 512'(u_tvalid_in), 512'(0));
        chk("rst_u_tready_out", 512'(u_tready_out), 512'(0));
        chk("rst_digest", 512'({m_tdigest, m_tblocks}), 512'(0));
        chk("rst_core_chain", 512'({u_A, u_B, u_C, u_D, u_E}), 512'(0));
    endtask

    // Stub core: accepts a block, returns the next programmed result 10 cycles later.
    initial begin : stub
        bit hs_in, hs_out, busy;
        int lat;
        logic [159:0] cur;
        busy = 0; lat = 0; cur = '0;
        forever begin
            @(negedge clk);
            hs_in  = reset_n && u_tvalid_in && u_tready_in;
            hs_out = reset_n && u_tvalid_out && u_tready_out;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                busy = 0;
                u_tvalid_out = 1'b0;
            end else begin
                if (hs_out) u_tvalid_out = 1'b0;
                if (hs_in) begin
                    busy = 1;
                    lat = 10;
                    cur = (res_q.size() != 0) ? res_q.pop_front() : '0;
                end else if (busy) begin
                    lat--;
                    if (lat == 0) begin
                        busy = 0;
                        u_tvalid_out = 1'b1;
                        {r_A, r_B, r_C, r_D, r_E} = cur;
                    end
                end
                u_tready_in = (in_stall == 0);
                if (u_tvalid_in && in_stall > 0) in_stall--;
            end
        end
    end

    initial begin : consumer
        forever begin
            @(posedge clk);
            #1;
            m_tready = (m_stall == 0);
            if (m_tvalid && m_stall > 0) m_stall--;
        end
    end

    // Compare process: checks every handshake phase against the model queues.
    always @(negedge clk) begin
        if (reset_n) begin
            logic [511:0] blk;
            chk("one_phase", 512'($countones({s_tready, u_tvalid_in, u_tready_out, m_tvalid}) <= 1), 512'(1));
            if (u_tvalid_in) begin
                if (exp_in_q.size() == 0) begin
                    chk("issue_unexpected", 512'(u_tvalid_in), 512'(0));
                end else begin
                    for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = u_data_in[i];
                    chk("core_chain", 512'({u_A, u_B, u_C, u_D, u_E}), 512'(exp_in_q[0]));
                    chk("core_data", blk, exp_blk_q[0]);
                    chk("core_pad", 512'(u_data_in[79:16] == '0), 512'(1));
                    if (u_tready_in) begin
                        last_core_in = exp_in_q.pop_front();
                        void'(exp_blk_q.pop_front());
                    end
                end
            end
            if (m_tvalid) begin
                if (exp_dig_q.size() == 0) begin
                    chk("digest_unexpected", 512'(m_tvalid), 512'(0));
                end else begin
                    chk("digest", 512'(m_tdigest), 512'(exp_dig_q[0]));
                    chk("blocks", 512'(m_tblocks), 512'(exp_cnt_q[0]));
                    if (m_tready) begin
                        last_dig = m_tdigest;
                        last_blocks = int'(m_tblocks);
                        void'(exp_dig_q.pop_front());
                        void'(exp_cnt_q.pop_front());
                    end
                end
            end
        end
    end

    // mode: 0 zero result, 1 ones, 2 all-F, other random.
    task automatic send_msg(input int nblk, input int mode, input int istall, input int ostall);
        logic [159:0] ch, r;
        logic [511:0] d;
        int to;
        ch = IV;
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
            case (mode)
                0: r = '0;
                1: r = {5{32'h0000_0001}};
                2: r = {5{32'hFFFF_FFFF}};
                default: for (int w = 0; w < 5; w++) r[32*w +: 32] = $urandom;
            endcase
            exp_in_q.push_back(ch);
            exp_blk_q.push_back(d);
            res_q.push_back(r);
            ch = hadd(ch, r);
            if (b == 0) in_stall = istall;
            s_tvalid = 1'b1;
            s_tdata  = d;
            s_tlast  = (b == nblk - 1);
            to = 0;
            do begin
                @(negedge clk);
                to++;
            end while (!s_tready && to < 2000);
            if (!s_tready) chk("accept_timeout", 512'(s_tready), 512'(1));
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
        exp_dig_q.push_back(ch);
        exp_cnt_q.push_back((nblk > CNT_MAX) ? CNT_MAX : nblk);
        m_stall = ostall;
    endtask

    task automatic wait_drain();
        int to;
        to = 0;
        while ((exp_dig_q.size() != 0 || exp_in_q.size() != 0) && to < 3000) begin
            @(negedge clk);
            to++;
        end
        chk("drain_timeout", 512'(exp_dig_q.size() + exp_in_q.size()), 512'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        repeat (3) @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("s_tready_before_edge", 512'(s_tready), 512'(0));
        @(negedge clk);
        chk("s_tready_idle", 512'(s_tready), 512'(1));
        @(posedge clk);
        #1;

        send_msg(1, 0, 0, 0);
        wait_drain();
        chk("lit_zero_digest", 512'(last_dig), 512'(IV));
        chk("lit_zero_blocks", 512'(last_blocks), 512'(1));

        send_msg(2, 1, 0, 0);
        wait_drain();
        chk("lit_ones_core_in2", 512'(last_core_in), 512'(160'h67452302_EFCDAB8A_98BADCFF_10325477_C3D2E1F1));
        chk("lit_ones_digest", 512'(last_dig), 512'(160'h67452303_EFCDAB8B_98BADD00_10325478_C3D2E1F2));
        chk("lit_ones_blocks", 512'(last_blocks), 512'(2));

        send_msg(1, 2, 0, 0);
        wait_drain();
        chk("lit_wrap_digest", 512'(last_dig), 512'(160'h67452300_EFCDAB88_98BADCFD_10325475_C3D2E1EF));

        send_msg(1, 3, 5, 0);
        wait_drain();

        // Digest held for 20 cycles while the next message is already waiting at the input.
        send_msg(2, 3, 0, 20);
        send_msg(1, 3, 0, 0);
        wait_drain();
        chk("lit_b2b_blocks", 512'(last_blocks), 512'(1));

        send_msg(1, 3, 0, 0);
        begin
            int to;
            to = 0;
            while (exp_in_q.size() != 0 && to < 200) begin
                @(negedge clk);
                to++;
            end
            chk("issue_before_reset", 512'(exp_in_q.size()), 512'(0));
        end
        repeat (4) @(posedge clk);
        #1;
        chk("in_wait_before_reset", 512'(u_tready_out), 512'(1));
        reset_n = 1'b0;
        res_q.delete();
        exp_in_q.delete();
        exp_blk_q.delete();
        exp_dig_q.delete();
        exp_cnt_q.delete();
        m_stall = 0;
        in_stall = 0;
        repeat (2) @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_msg(1, 1, 0, 0);
        wait_drain();
        chk("lit_post_reset_digest", 512'(last_dig), 512'(160'h67452302_EFCDAB8A_98BADCFF_10325477_C3D2E1F1));
        chk("lit_post_reset_blocks", 512'(last_blocks), 512'(1));

        send_msg(CNT_MAX + 2, 3, 0, 0);
        wait_drain();
        chk("lit_sat_blocks", 512'(last_blocks), 512'(CNT_MAX));

        for (int n = 0; n < 6; n++) begin
            send_msg(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
